// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter sequencing a fixed-latency synchronous data memory.
// Define DMEM_ARB_RR_EN for round-robin grant; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic [1:0]    req0_memwrite,
  input  logic [2:0]    req0_readmode,
  output logic          req0_rvalid,
  output logic [DW-1:0] req0_rdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic [1:0]    req1_memwrite,
  input  logic [2:0]    req1_readmode,
  output logic          req1_rvalid,
  output logic [DW-1:0] req1_rdata,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [1:0]    mem_memwrite,
  output logic [2:0]    mem_readmode,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    memwrite_q, memwrite_d;
  logic [2:0]    readmode_q, readmode_d;
  logic          owner_q, owner_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          gnt1, acc, resp;
  logic [DW-1:0] rdata_v;
`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;
  // last_q set means port 1 was served last, so port 0 wins a tie
  assign gnt1   = req1_valid & (!req0_valid | !last_q);
  assign last_d = acc ? gnt1 : last_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b1;
    else        last_q <= last_d;
`else
  assign gnt1 = req1_valid & !req0_valid;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      memwrite_q <= '0;
      readmode_q <= '0;
      owner_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      memwrite_q <= memwrite_d;
      readmode_q <= readmode_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = acc ? (gnt1 ? req1_addr : req0_addr) : addr_q;
    wdata_d    = acc ? (gnt1 ? req1_wdata : req0_wdata) : wdata_q;
    memwrite_d = acc ? (gnt1 ? req1_memwrite : req0_memwrite) : memwrite_q;
    readmode_d = acc ? (gnt1 ? req1_readmode : req0_readmode) : readmode_q;
    owner_d    = acc ? gnt1 : owner_q;
    case (state_q)
      IDLE:  state_d = acc ? ISSUE : IDLE;
      ISSUE: begin
        cnt_d   = 3'(RD_LAT - 1);
        state_d = (RD_LAT == 1) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q - 3'd1;
        state_d = (cnt_q == 3'd1) ? RESP : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req0_ready   = reset & (state_q == IDLE) & req0_valid & !gnt1;
    req1_ready   = reset & (state_q == IDLE) & gnt1;
    acc          = req0_ready | req1_ready;
    busy         = state_q != IDLE;
    mem_en       = state_q == ISSUE;
    mem_memwrite = mem_en ? memwrite_q : 2'b00;
    mem_addr     = addr_q;
    mem_wdata    = wdata_q;
    mem_readmode = readmode_q;
    resp         = state_q == RESP;
    rdata_v      = (memwrite_q == 2'b00) ? mem_rdata : '0;
    req0_rvalid  = resp & !owner_q;
    req1_rvalid  = resp & owner_q;
    req0_rdata   = req0_rvalid ? rdata_v : '0;
    req1_rdata   = req1_rvalid ? rdata_v : '0;
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter at read latencies 1, 2 and 4.
module tb_dmem_arbiter;
  logic        clk, reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata, mem_rdata;
  logic [1:0]  req0_memwrite, req1_memwrite;
  logic [2:0]  req0_readmode, req1_readmode;
  logic        r0_rdy[3], r1_rdy[3], r0_v[3], r1_v[3], men[3], bsy[3];
  logic [31:0] r0_d[3], r1_d[3], maddr[3], mwd[3];
  logic [1:0]  mmw[3];
  logic [2:0]  mrm[3];
  int n_cmp = 0, n_bad = 0;

  for (genvar k = 0; k < 3; k++) begin : g
    dmem_arbiter #(.AW(32), .DW(32), .RD_LAT(k == 0 ? 1 : (k == 1 ? 2 : 4))) u (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(r0_rdy[k]), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_memwrite(req0_memwrite), .req0_readmode(req0_readmode),
      .req0_rvalid(r0_v[k]), .req0_rdata(r0_d[k]),
      .req1_valid(req1_valid), .req1_ready(r1_rdy[k]), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_memwrite(req1_memwrite), .req1_readmode(req1_readmode),
      .req1_rvalid(r1_v[k]), .req1_rdata(r1_d[k]),
      .mem_en(men[k]), .mem_addr(maddr[k]), .mem_wdata(mwd[k]), .mem_memwrite(mmw[k]),
      .mem_readmode(mrm[k]), .mem_rdata(mem_rdata), .busy(bsy[k]));
  end

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 0;
    reset = 0;
    @(negedge clk);
    reset = 1;
  endtask

  typedef struct {logic v0, v1, e0, e1;} vec_t;
  vec_t tbl[4];

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int last, nacc, n, cnt, exp_p;
    bit found;
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0};
    tbl[2] = '{0, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 0};
    clk = 0; reset = 0;
    req0_valid = 1; req1_valid = 1;
    req0_addr = 32'h55; req1_addr = 32'h66; req0_wdata = 0; req1_wdata = 0;
    req0_memwrite = 0; req1_memwrite = 0; req0_readmode = 3'b010; req1_readmode = 3'b010;
    mem_rdata = 32'hDEADBEEF;
    #12;
    chk("rst_ready0", r0_rdy[1], 0);
    chk("rst_busy", bsy[1], 0);
    chk("rst_mem_en", men[1], 0);
    chk("rst_mem_addr", maddr[1], 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = tbl[i].v0;
      req1_valid = tbl[i].v1;
      #1;
      chk($sformatf("tbl%0d_ready0", i), r0_rdy[1], tbl[i].e0);
      chk($sformatf("tbl%0d_ready1", i), r1_rdy[1], tbl[i].e1);
      chk($sformatf("tbl%0d_busy", i), bsy[1], 0);
      req0_valid = 0;
      req1_valid = 0;
    end
    // port 0 load, RD_LAT=2
    do_reset();
    req0_valid = 1; req0_addr = 32'h10; req0_readmode = 3'b010; req0_memwrite = 0;
    #1 chk("a_ready0", r0_rdy[1], 1);
    @(negedge clk);
    req0_valid = 0;
    #1;
    chk("a_issue_en", men[1], 1);
    chk("a_issue_addr", maddr[1], 32'h10);
    chk("a_issue_rm", mrm[1], 3'b010);
    chk("a_issue_busy", bsy[1], 1);
    chk("a_issue_rv", r0_v[1], 0);
    @(negedge clk);
    #1;
    chk("a_wait_en", men[1], 0);
    chk("a_wait_busy", bsy[1], 1);
    chk("a_wait_rv", r0_v[1], 0);
    @(negedge clk);
    #1;
    chk("a_resp_rv0", r0_v[1], 1);
    chk("a_resp_rd0", r0_d[1], 32'hDEADBEEF);
    chk("a_resp_rv1", r1_v[1], 0);
    chk("a_resp_rd1", r1_d[1], 0);
    chk("a_resp_busy", bsy[1], 1);
    @(negedge clk);
    #1;
    chk("a_done_busy", bsy[1], 0);
    chk("a_done_rv", r0_v[1], 0);
    // port 1 word store, RD_LAT=2
    do_reset();
    req1_valid = 1; req1_addr = 32'h20; req1_wdata = 32'h12345678; req1_memwrite = 2'b11;
    #1;
    chk("b_ready1", r1_rdy[1], 1);
    chk("b_ready0", r0_rdy[1], 0);
    @(negedge clk);
    req1_valid = 0;
    #1;
    chk("b_issue_mw", mmw[1], 2'b11);
    chk("b_issue_wd", mwd[1], 32'h12345678);
    chk("b_issue_en", men[1], 1);
    @(negedge clk);
    #1;
    chk("b_wait_mw", mmw[1], 2'b00);
    chk("b_wait_addr", maddr[1], 32'h20);
    @(negedge clk);
    #1;
    chk("b_resp_rv1", r1_v[1], 1);
    chk("b_resp_rd1", r1_d[1], 0);
    chk("b_resp_rv0", r0_v[1], 0);
    chk("b_resp_mw", mmw[1], 2'b00);
    req1_memwrite = 0;
    // both valid continuously, RD_LAT=1
    do_reset();
    req0_valid = 1; req1_valid = 1;
    exp_p = 0;
    for (int s = 0; s < 15; s++) begin
      #1;
      if (!bsy[0]) begin
        chk("c_gnt0", r0_rdy[0], exp_p == 0);
        chk("c_gnt1", r1_rdy[0], exp_p == 1);
`ifdef DMEM_ARB_RR_EN
        exp_p = 1 - exp_p;
`endif
      end else begin
        chk("c_busy_ready1", r1_rdy[0], 0);
      end
      @(negedge clk);
    end
    // reset during WAIT, RD_LAT=4
    do_reset();
    req1_valid = 0;
    req0_valid = 1; req0_addr = 32'h44; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("d_wait_busy", bsy[2], 1);
    reset = 0;
    #1;
    chk("d_rst_busy", bsy[2], 0);
    chk("d_rst_en", men[2], 0);
    chk("d_rst_rv", r0_v[2] | r1_v[2], 0);
    chk("d_rst_addr", maddr[2], 0);
    @(negedge clk);
    reset = 1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1 cnt += int'(r0_v[2] | r1_v[2] | bsy[2]);
    end
    chk("d_no_resp", cnt, 0);
    @(negedge clk);
    req0_valid = 1; req0_addr = 32'h48;
    n = 0; found = 0;
    for (int i = 1; i <= 10 && !found; i++) begin
      @(negedge clk);
      if (i == 1) req0_valid = 0;
      #1;
      if (r0_v[2]) begin
        found = 1;
        n = i;
      end
    end
    chk("d_lat", n, 5);
    chk("d_rdata", r0_d[2], 32'hCAFEF00D);
    // back-to-back port 0 loads, RD_LAT=1
    do_reset();
    req0_valid = 1;
    last = -100; nacc = 0;
    for (int s = 0; s < 12; s++) begin
      #1;
      if (r0_rdy[0]) begin
        if (last >= 0) chk("e_gap", s - last, 3);
        last = s;
        nacc++;
      end
      if (r0_v[0]) chk("e_lat", s - last, 2);
      @(negedge clk);
    end
    req0_valid = 0;
    chk("e_nacc", nacc, 4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
